// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: widths, RV32I funct3 access
// encodings, the FSM state type and a funct3 legality helper.
package lsu_pkg;

    localparam int D_WIDTH  = 32;
    localparam int A_WIDTH  = 32;
    localparam int BE_WIDTH = D_WIDTH / 8;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // Stores only exist in signed-size form; loads also allow the unsigned sizes.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !we;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_format.sv
// Combinational data formatting for the load/store unit: store byte enables and
// lane replication, plus load byte/half selection with sign or zero extension.
module lsu_format
    import lsu_pkg::*;
(
    input  logic [2:0]          st_funct3,
    input  logic [1:0]          st_addr_lo,
    input  logic [D_WIDTH-1:0]  st_wdata,
    output logic [BE_WIDTH-1:0] st_be,
    output logic [D_WIDTH-1:0]  st_lanes,
    input  logic [2:0]          ld_funct3,
    input  logic [1:0]          ld_addr_lo,
    input  logic [D_WIDTH-1:0]  ld_word,
    output logic [D_WIDTH-1:0]  ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Replicate the store data into every lane it could land in and enable only the addressed lanes.
    always_comb begin
        st_be    = 4'b1111;
        st_lanes = st_wdata;
        case (st_funct3)
            F3_B, F3_BU: begin
                st_be    = 4'b0001 << st_addr_lo;
                st_lanes = {4{st_wdata[7:0]}};
            end
            F3_H, F3_HU: begin
                st_be    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
                st_lanes = {2{st_wdata[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_lanes = st_wdata;
            end
        endcase
    end

    // Pick the addressed byte/half out of the bus word and extend it to a full register value.
    always_comb begin
        byte_sel = ld_word[{ld_addr_lo, 3'b000} +: 8];
        half_sel = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            F3_W:    ld_data = ld_word;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle RV32I load/store unit: accepts an ALU address and store data,
// runs one request/acknowledge bus transfer and returns extended load data,
// stalling the core while the transfer is outstanding.
// Optional feature macro: LSU_MISALIGN_TRAP_EN rejects misaligned H/W accesses.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int d_width = D_WIDTH,
    parameter int a_width = A_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    input  logic               req_we,
    input  logic [2:0]         funct3,
    input  logic [a_width-1:0] addr,
    input  logic [d_width-1:0] wdata,
    output logic               stall,
    output logic               resp_valid,
    output logic [d_width-1:0] rdata,
    output logic               err,
    output logic               bus_req,
    output logic               bus_we,
    output logic [a_width-1:0] bus_addr,
    output logic [3:0]         bus_be,
    output logic [d_width-1:0] bus_wdata,
    input  logic               bus_ack,
    input  logic [d_width-1:0] bus_rdata
);

    lsu_state_e         state_q, state_d;
    logic [a_width-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]         bus_be_q, bus_be_d;
    logic [d_width-1:0] bus_wdata_q, bus_wdata_d;
    logic               bus_we_q, bus_we_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         addr_lo_q, addr_lo_d;
    logic               rej_q, rej_d;
    logic [d_width-1:0] rdata_q, rdata_d;

    logic               access_legal;
    logic [3:0]         fmt_be;
    logic [d_width-1:0] fmt_lanes;
    logic [d_width-1:0] fmt_load;

    lsu_format u_format (
        .st_funct3  (funct3),
        .st_addr_lo (addr[1:0]),
        .st_wdata   (wdata),
        .st_be      (fmt_be),
        .st_lanes   (fmt_lanes),
        .ld_funct3  (funct3_q),
        .ld_addr_lo (addr_lo_q),
        .ld_word    (bus_rdata),
        .ld_data    (fmt_load)
    );

    // Decide whether the incoming request may be issued on the bus at all.
    always_comb begin
        access_legal = f3_legal(req_we, funct3);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((funct3 == F3_H || funct3 == F3_HU) && addr[0]) begin
            access_legal = 1'b0;
        end
        if (funct3 == F3_W && addr[1:0] != 2'b00) begin
            access_legal = 1'b0;
        end
`endif
    end

    // Next-state and stall logic: IDLE accepts or rejects, BUS waits for ack, DONE reports for one cycle.
    always_comb begin
        state_d     = state_q;
        bus_addr_d  = bus_addr_q;
        bus_be_d    = bus_be_q;
        bus_wdata_d = bus_wdata_q;
        bus_we_d    = bus_we_q;
        funct3_d    = funct3_q;
        addr_lo_d   = addr_lo_q;
        rej_d       = rej_q;
        rdata_d     = rdata_q;
        stall       = 1'b0;
        case (state_q)
            IDLE: begin
                stall = req_valid;
                if (req_valid) begin
                    rej_d   = !access_legal;
                    rdata_d = '0;
                    if (access_legal) begin
                        bus_addr_d  = {addr[a_width-1:2], 2'b00};
                        bus_be_d    = fmt_be;
                        bus_wdata_d = fmt_lanes;
                        bus_we_d    = req_we;
                        funct3_d    = funct3;
                        addr_lo_d   = addr[1:0];
                        state_d     = BUS;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            BUS: begin
                stall = 1'b1;
                if (bus_ack) begin
                    rdata_d = bus_we_q ? '0 : fmt_load;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and transfer registers; reset abandons any transfer in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bus_addr_q  <= '0;
            bus_be_q    <= '0;
            bus_wdata_q <= '0;
            bus_we_q    <= 1'b0;
            funct3_q    <= '0;
            addr_lo_q   <= '0;
            rej_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            bus_addr_q  <= bus_addr_d;
            bus_be_q    <= bus_be_d;
            bus_wdata_q <= bus_wdata_d;
            bus_we_q    <= bus_we_d;
            funct3_q    <= funct3_d;
            addr_lo_q   <= addr_lo_d;
            rej_q       <= rej_d;
            rdata_q     <= rdata_d;
        end
    end

    assign bus_req    = (state_q == BUS);
    assign bus_we     = bus_we_q;
    assign bus_addr   = bus_addr_q;
    assign bus_be     = bus_be_q;
    assign bus_wdata  = bus_wdata_q;
    assign resp_valid = (state_q == DONE) && !rej_q;
    assign err        = (state_q == DONE) && rej_q;
    assign rdata      = rdata_q;

endmodule
